axi4_write_data: RTL and testbench
==================================

# axi4_write_data

Write-path counterpart of the DDR read-data streamer: accepts a 512-bit AXI4-Stream from the DMA MM2S channel, buffers it in an internal FIFO, and hands one beat per DDR write-data request to the DDR4 interface. The DDR side pulls data and cannot be stalled, so the block exposes its occupancy to the command issuer and flags any request that finds the buffer empty. It sits between the DMA MM2S port and the DDR4 write datapath, in the single `clk` domain.

## Interface
- `DATA_W`, 512, stream and DDR data width.
- `KEEP_W`, `DATA_W/8`, byte-enable width.
- `DEPTH`, 64, FIFO entries; power of two, at least 4.
- `CNT_W`, `$clog2(DEPTH)+1`, occupancy counter width.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `S_AXIS_TDATA`  in  DATA_W  stream data from DMA MM2S.
- `S_AXIS_TKEEP`  in  KEEP_W  byte enables.
- `S_AXIS_TVALID`  in  1  beat valid.
- `S_AXIS_TLAST`  in  1  last beat of packet.
- `S_AXIS_TREADY`  out  1  block can accept a beat.
- `ddr_wr_req`  in  1  DDR consumes one beat this cycle; never held off.
- `ddr_wr_data`  out  DATA_W  write data, registered.
- `ddr_wr_mask`  out  KEEP_W  byte mask, 1 = byte not written (`~TKEEP`).
- `ddr_wr_valid`  out  1  `ddr_wr_data`/`ddr_wr_mask` carry a real beat.
- `data_count`  out  CNT_W  beats currently buffered.
- `pkt_count`  out  16  TLAST beats accepted since reset; wraps at 2^16.
- `err_clr`  in  1  clears `underflow_err`.
- `underflow_err`  out  1  sticky: `ddr_wr_req` arrived while empty.
- `latest_data_monitor`  out  16  `ddr_wr_data[15:0]` of the last valid beat.

## Operation
- The FIFO entry is `{TLAST, TKEEP, TDATA}`.
- **Push:** `S_AXIS_TVALID && S_AXIS_TREADY`. `S_AXIS_TREADY = ready_en && (data_count != DEPTH)`. `ready_en` is a register cleared by reset and set on the first cycle after `rst_n` goes high.
- **Pop:** `ddr_wr_req && (data_count != 0)`. The entry registers into `ddr_wr_data`/`ddr_wr_mask`, and `ddr_wr_valid` is set for one cycle.
- **Underflow:** `ddr_wr_req && data_count == 0`.
  - `ddr_wr_valid` = 0.
  - `ddr_wr_data` = 0.
  - `ddr_wr_mask` = all ones, so DDR writes nothing.
  - `underflow_err` is set.
  - Pointers are unchanged.
- **`underflow_err`:** cleared by `err_clr`. Setting has priority over `err_clr` in the same cycle.
- **Counters:**
  - `data_count` changes by +1 on push-only, -1 on pop-only, and is unchanged on simultaneous push and pop.
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally.
- **Simultaneous push and pop:**
  - When full, push cannot occur because TREADY is 0. The pop frees a slot, and TREADY rises the next cycle.
  - When empty, there is no bypass. The push is stored, the request underflows, and `data_count` becomes 1.
- **`pkt_count`:** increments on a push with TLAST = 1.
- **Stored state:** TLAST is stored but not forwarded; it is used only for `pkt_count`.
- **Reset mid-operation:** FIFO contents are discarded, all counters and outputs return to reset values, and any beat offered during reset is not accepted.

## Timing
- Reset values:
  - `S_AXIS_TREADY`, `ddr_wr_valid`, `ddr_wr_data`, `underflow_err`, `data_count`, `pkt_count`, `latest_data_monitor`: 0.
  - `ddr_wr_mask`: all ones.
- TREADY is 1 from the second rising edge after `rst_n` deasserts.
- Pop latency: `ddr_wr_req` at edge N gives `ddr_wr_valid` and data valid after edge N, i.e. one-cycle latency.
- Throughput: one pop per cycle sustained.
- Push-to-pop: a beat pushed at edge N can be popped by a request at edge N+1. `data_count` reflects it after edge N.
- `data_count`, `S_AXIS_TREADY` and `underflow_err` update on the same edge as the push or pop that causes them.

## Structure
- **Shared package `sddt_ddr_pkg`:** `DATA_W`, `KEEP_W`, and the FIFO entry width constant `DATA_W+KEEP_W+1`, shared with the read-data streamer.
- **Sub-module `sync_fifo_fwft`:** a parameterised single-clock RAM FIFO with registered read and count output, reusable elsewhere. The top level holds the ready, error, packet-counter and mask logic.

## Test plan
- **Reset state:** hold `rst_n`=0 for 5 cycles with TVALID=1, then release. Required: TREADY=0 during reset and 1 on the second edge after release, mask=all ones, `data_count`=0.
- **Single beat:** push TDATA=0xA5…, TKEEP=0xFFFF_FFFF_FFFF_000F, TLAST=1, then `ddr_wr_req` for one cycle. Required: the next cycle shows `ddr_wr_valid`=1, data = the pushed TDATA, mask = 0x0000_0000_0000_FFF0, `pkt_count`=1, `latest_data_monitor`=0x…A5A5.
- **Fill:** push 64 beats with no requests. Required: `data_count`=64, TREADY=0. Then one request: TREADY=1 the following cycle and the 65th beat is accepted with in-order data.
- **Underflow:** request while empty. Required: `ddr_wr_valid`=0, data=0, mask all ones, `underflow_err`=1 and sticky. Assert `err_clr` together with a new underflow: error stays 1. Assert `err_clr` alone: error drops to 0.
- **Streaming with wrap:** drive 200 beats carrying an incrementing pattern with continuous requests after 4 are buffered. Required: pointers wrap, output order matches, `data_count` stays at 4, no underflow.
- **Reset mid-operation:** reset with 10 beats buffered. Required: `data_count`=0, `pkt_count`=0, and the first pop after reset underflows.

Source files
------------

// File: rtl/sddt_ddr_pkg.sv
// Widths shared by the DDR read-data and write-data streamers.
package sddt_ddr_pkg;
  localparam int DATA_W  = 512;
  localparam int KEEP_W  = DATA_W / 8;
  localparam int ENTRY_W = DATA_W + KEEP_W + 1;
endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock RAM FIFO with a registered read port and an occupancy count.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             underrun,
  output logic [CNT_W-1:0] count,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic             empty;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push     = wr_en && !full;
  assign pop      = rd_en && !empty;
  assign underrun = rd_en && empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Read stage: a request that finds nothing loads an all-zero word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end else if (underrun) begin
        rd_data <= '0;
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/axi4_write_data.sv
// AXI4-Stream to DDR4 write-data buffer; DDR pulls one beat per request.
module axi4_write_data
  import sddt_ddr_pkg::*;
#(
  parameter int DATA_W = sddt_ddr_pkg::DATA_W,
  parameter int KEEP_W = DATA_W / 8,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] S_AXIS_TDATA,
  input  logic [KEEP_W-1:0] S_AXIS_TKEEP,
  input  logic              S_AXIS_TVALID,
  input  logic              S_AXIS_TLAST,
  output logic              S_AXIS_TREADY,
  input  logic              ddr_wr_req,
  output logic [DATA_W-1:0] ddr_wr_data,
  output logic [KEEP_W-1:0] ddr_wr_mask,
  output logic              ddr_wr_valid,
  output logic [CNT_W-1:0]  data_count,
  output logic [15:0]       pkt_count,
  input  logic              err_clr,
  output logic              underflow_err,
  output logic [15:0]       latest_data_monitor
);
  localparam int FIFO_W = DATA_W + KEEP_W + 1;

  logic              ready_en;
  logic              full;
  logic              push;
  logic              underrun;
  logic [FIFO_W-1:0] head;
  logic [15:0]       mon_q;
  logic              unused_last;

  assign S_AXIS_TREADY = ready_en && !full;
  assign push          = S_AXIS_TVALID && S_AXIS_TREADY;

  sync_fifo_fwft #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (push),
    .wr_data  ({S_AXIS_TLAST, S_AXIS_TKEEP, S_AXIS_TDATA}),
    .rd_en    (ddr_wr_req),
    .rd_data  (head),
    .rd_valid (ddr_wr_valid),
    .underrun (underrun),
    .count    (data_count),
    .full     (full)
  );

  // A zeroed head (reset or underflow) turns into an all-ones mask.
  assign ddr_wr_data = head[DATA_W-1:0];
  assign ddr_wr_mask = ~head[DATA_W +: KEEP_W];
  assign unused_last = head[FIFO_W-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_en      <= 1'b0;
      underflow_err <= 1'b0;
      pkt_count     <= '0;
      mon_q         <= '0;
    end else begin
      ready_en <= 1'b1;
      if (underrun) begin
        underflow_err <= 1'b1;
      end else if (err_clr) begin
        underflow_err <= 1'b0;
      end
      if (push && S_AXIS_TLAST) pkt_count <= pkt_count + 16'd1;
      if (ddr_wr_valid) mon_q <= ddr_wr_data[15:0];
    end
  end

  assign latest_data_monitor = ddr_wr_valid ? ddr_wr_data[15:0] : mon_q;
endmodule

// File: tb/tb_axi4_write_data.sv
// Directed bench for axi4_write_data: vector table plus multi-cycle sequences.
module tb_axi4_write_data;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic         tvalid;
  logic         tlast;
  logic         tready;
  logic         req;
  logic [511:0] wr_data;
  logic [63:0]  wr_mask;
  logic         wr_valid;
  logic [6:0]   count;
  logic [15:0]  pkt;
  logic         clr;
  logic         err;
  logic [15:0]  mon;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi4_write_data dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .S_AXIS_TDATA        (tdata),
    .S_AXIS_TKEEP        (tkeep),
    .S_AXIS_TVALID       (tvalid),
    .S_AXIS_TLAST        (tlast),
    .S_AXIS_TREADY       (tready),
    .ddr_wr_req          (req),
    .ddr_wr_data         (wr_data),
    .ddr_wr_mask         (wr_mask),
    .ddr_wr_valid        (wr_valid),
    .data_count          (count),
    .pkt_count           (pkt),
    .err_clr             (clr),
    .underflow_err       (err),
    .latest_data_monitor (mon)
  );

  typedef struct {
    logic         tvalid;
    logic [511:0] tdata;
    logic [63:0]  tkeep;
    logic         tlast;
    logic         req;
    logic         clr;
    logic         chk_out;
    logic         e_valid;
    logic [511:0] e_data;
    logic [63:0]  e_mask;
    logic [6:0]   e_count;
    logic [15:0]  e_pkt;
    logic         e_err;
    logic [15:0]  e_mon;
  } vec_t;

  vec_t vt[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mkdata(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {16{w}};
  endfunction

  function automatic vec_t mkv(input logic v, input logic [511:0] d, input logic [63:0] k,
                               input logic l, input logic r, input logic c, input logic co,
                               input logic ev, input logic [511:0] ed, input logic [63:0] em,
                               input logic [6:0] ec, input logic [15:0] ep, input logic ee,
                               input logic [15:0] emon);
    vec_t x;
    x.tvalid = v; x.tdata = d; x.tkeep = k; x.tlast = l; x.req = r; x.clr = c;
    x.chk_out = co; x.e_valid = ev; x.e_data = ed; x.e_mask = em;
    x.e_count = ec; x.e_pkt = ep; x.e_err = ee; x.e_mon = emon;
    return x;
  endfunction

  initial begin
    logic [511:0] da5, db, dc, z;
    logic [63:0]  ka, ones;
    da5  = {64{8'hA5}};
    db   = {32{16'h1234}};
    dc   = {64{8'h3C}};
    z    = '0;
    ka   = 64'hFFFF_FFFF_FFFF_000F;
    ones = '1;

    //        tv  tdata keep  tl  req clr chk  ev  edata  emask                  cnt   pkt    err  mon
    vt[0] = mkv(1, da5, ka,   1,  0,  0,  1,   0,  z,     ones,                  7'd1, 16'd1, 0,   16'h0000);
    vt[1] = mkv(0, z,   ones, 0,  1,  0,  1,   1,  da5,   64'h0000_0000_0000_FFF0, 7'd0, 16'd1, 0, 16'hA5A5);
    vt[2] = mkv(0, z,   ones, 0,  1,  0,  1,   0,  z,     ones,                  7'd0, 16'd1, 1,   16'hA5A5);
    vt[3] = mkv(0, z,   ones, 0,  0,  0,  0,   0,  z,     ones,                  7'd0, 16'd1, 1,   16'hA5A5);
    vt[4] = mkv(0, z,   ones, 0,  1,  1,  1,   0,  z,     ones,                  7'd0, 16'd1, 1,   16'hA5A5);
    vt[5] = mkv(0, z,   ones, 0,  0,  1,  0,   0,  z,     ones,                  7'd0, 16'd1, 0,   16'hA5A5);
    vt[6] = mkv(1, db,  ones, 0,  1,  0,  1,   0,  z,     ones,                  7'd1, 16'd1, 1,   16'hA5A5);
    vt[7] = mkv(0, z,   ones, 0,  1,  1,  1,   1,  db,    64'h0,                 7'd0, 16'd1, 0,   16'h1234);
    vt[8] = mkv(1, dc,  64'h0, 1, 0,  0,  0,   0,  z,     ones,                  7'd1, 16'd2, 0,   16'h1234);
    vt[9] = mkv(0, z,   ones, 0,  1,  0,  1,   1,  dc,    ones,                  7'd0, 16'd2, 0,   16'h3C3C);

    // Reset with a beat offered throughout
    rst_n = 1'b0; tvalid = 1'b1; tdata = da5; tkeep = ones; tlast = 1'b1; req = 1'b0; clr = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("rst_tready", tready, 1'b0);
    chk("rst_mask", wr_mask, ones);
    chk("rst_count", count, 7'd0);
    chk("rst_valid", wr_valid, 1'b0);
    chk("rst_data", wr_data, z);
    chk("rst_pkt", pkt, 16'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_mon", mon, 16'd0);
    rst_n = 1'b1; tvalid = 1'b0;
    #1;
    chk("release_tready_early", tready, 1'b0);
    tick();
    tick();
    chk("release_tready", tready, 1'b1);
    chk("release_count", count, 7'd0);

    for (int i = 0; i < 10; i++) begin
      tvalid = vt[i].tvalid; tdata = vt[i].tdata; tkeep = vt[i].tkeep;
      tlast = vt[i].tlast; req = vt[i].req; clr = vt[i].clr;
      tick();
      if (vt[i].chk_out) begin
        chk($sformatf("vec%0d_valid", i), wr_valid, vt[i].e_valid);
        chk($sformatf("vec%0d_data", i), wr_data, vt[i].e_data);
        chk($sformatf("vec%0d_mask", i), wr_mask, vt[i].e_mask);
      end
      chk($sformatf("vec%0d_count", i), count, vt[i].e_count);
      chk($sformatf("vec%0d_pkt", i), pkt, vt[i].e_pkt);
      chk($sformatf("vec%0d_err", i), err, vt[i].e_err);
      chk($sformatf("vec%0d_mon", i), mon, vt[i].e_mon);
      chk($sformatf("vec%0d_tready", i), tready, 1'b1);
    end
    tvalid = 1'b0; req = 1'b0; clr = 1'b0; tlast = 1'b0; tkeep = ones;

    // Fill to capacity, then one pop reopens a slot for the 65th beat
    for (int i = 0; i < 64; i++) begin
      tvalid = 1'b1; tdata = mkdata(i);
      tick();
    end
    tdata = mkdata(64);
    chk("fill_count", count, 7'd64);
    chk("fill_tready", tready, 1'b0);
    req = 1'b1;
    tick();
    chk("fill_pop_valid", wr_valid, 1'b1);
    chk("fill_pop_data", wr_data, mkdata(0));
    chk("fill_pop_count", count, 7'd63);
    chk("fill_reopen_tready", tready, 1'b1);
    req = 1'b0;
    tick();
    tvalid = 1'b0;
    chk("fill_65_count", count, 7'd64);
    req = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      chk($sformatf("drain%0d_data", i), wr_data, mkdata(i));
      chk($sformatf("drain%0d_valid", i), wr_valid, 1'b1);
    end
    req = 1'b0;
    chk("drain_count", count, 7'd0);

    // Streaming with pointer wrap: four buffered, then push and pop every cycle
    for (int i = 0; i < 4; i++) begin
      tvalid = 1'b1; tdata = mkdata(256 + i);
      tick();
    end
    chk("stream_prefill", count, 7'd4);
    for (int i = 4; i < 200; i++) begin
      tvalid = 1'b1; tdata = mkdata(256 + i); req = 1'b1;
      tick();
      chk($sformatf("stream%0d_data", i), wr_data, mkdata(256 + i - 4));
      chk($sformatf("stream%0d_valid", i), wr_valid, 1'b1);
      chk($sformatf("stream%0d_count", i), count, 7'd4);
      chk($sformatf("stream%0d_err", i), err, 1'b0);
    end
    tvalid = 1'b0;
    for (int i = 196; i < 200; i++) begin
      tick();
      chk($sformatf("tail%0d_data", i), wr_data, mkdata(256 + i));
      chk($sformatf("tail%0d_valid", i), wr_valid, 1'b1);
    end
    req = 1'b0;
    tick();
    chk("stream_end_count", count, 7'd0);
    chk("stream_end_err", err, 1'b0);

    // Reset with ten packets buffered
    tlast = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tvalid = 1'b1; tdata = mkdata(900 + i);
      tick();
    end
    chk("mid_pre_count", count, 7'd10);
    chk("mid_pre_pkt", pkt, 16'd12);
    rst_n = 1'b0;
    tick();
    tick();
    chk("mid_rst_count", count, 7'd0);
    chk("mid_rst_pkt", pkt, 16'd0);
    chk("mid_rst_tready", tready, 1'b0);
    chk("mid_rst_mask", wr_mask, ones);
    rst_n = 1'b1; tvalid = 1'b0; tlast = 1'b0;
    tick();
    tick();
    chk("mid_rel_count", count, 7'd0);
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("mid_uf_valid", wr_valid, 1'b0);
    chk("mid_uf_err", err, 1'b1);
    chk("mid_uf_data", wr_data, z);
    chk("mid_uf_mask", wr_mask, ones);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
